// File: rtl/md_pkg.sv
// Shared encodings and widths for the iterative multiply/divide unit.
package md_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MULS = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIVS = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/md_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
module md_step
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_next_c
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Mul: acc = {partial product, multiplier}; div: acc = {remainder, dividend/quotient}.
  always_comb begin
    sum        = '0;
    rem_sh     = '0;
    diff       = '0;
    acc_next_c = acc_i;
    if (is_div_i) begin
      rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
      diff   = (WIDTH+1)'(rem_sh - {1'b0, opnd_i});
      if (diff[WIDTH]) begin
        acc_next_c = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end else begin
        acc_next_c = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      sum = (WIDTH+1)'({1'b0, acc_i[2*WIDTH-1:WIDTH]} +
                       (acc_i[0] ? {1'b0, opnd_i} : (WIDTH+1)'(0)));
      acc_next_c = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 16-bit multiply/divide unit with fixed-latency busy/done handshake
// and hi/lo result registers.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_e          state_q, state_d;
  md_op_e             op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               sa_q, sa_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  md_op_e             op_in;
  logic               in_div, in_sgn, in_sa, in_sb;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               cur_div;
  logic [ACC_W-1:0]   step_acc;
  logic [ACC_W-1:0]   prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               accept;

  md_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i   (cur_div),
    .acc_i      (acc_q),
    .opnd_i     (opnd_q),
    .acc_next_c (step_acc)
  );

  // Operand decode and magnitudes; internal arithmetic is unsigned on these.
  always_comb begin
    op_in   = md_op_e'(op);
    in_div  = (op_in == OP_DIVU) || (op_in == OP_DIVS);
    in_sgn  = (op_in == OP_MULS) || (op_in == OP_DIVS);
    in_sa   = in_sgn & a[WIDTH-1];
    in_sb   = in_sgn & b[WIDTH-1];
    a_mag   = in_sa ? WIDTH'(-a) : a;
    b_mag   = in_sb ? WIDTH'(-b) : b;
    cur_div = (op_q == OP_DIVU) || (op_q == OP_DIVS);
    accept  = start && (state_q != ST_RUN);
  end

  // Sign correction of the final iteration's result.
  always_comb begin
    prod_fix = neg_q ? ACC_W'(-step_acc) : step_acc;
    quo_fix  = neg_q ? WIDTH'(-step_acc[WIDTH-1:0]) : step_acc[WIDTH-1:0];
    rem_fix  = sa_q ? WIDTH'(-step_acc[ACC_W-1:WIDTH]) : step_acc[ACC_W-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    araw_d  = araw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        acc_d = step_acc;
        cnt_d = CNT_W'(cnt_q - 1'b1);
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          if (cur_div && (opnd_q == '0)) begin
            hi_d  = araw_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else if (cur_div) begin
            hi_d  = rem_fix;
            lo_d  = quo_fix;
            dbz_d = 1'b0;
          end else begin
            hi_d  = prod_fix[ACC_W-1:WIDTH];
            lo_d  = prod_fix[WIDTH-1:0];
            dbz_d = 1'b0;
          end
        end
      end
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Operands are only sampled when a new request is taken.
    if (accept) begin
      op_d   = op_in;
      neg_d  = in_sa ^ in_sb;
      sa_d   = in_sa;
      araw_d = a;
      cnt_d  = CNT_W'(WIDTH - 1);
      opnd_d = in_div ? b_mag : a_mag;
      acc_d  = {WIDTH'(0), (in_div ? a_mag : b_mag)};
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULU;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      araw_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      araw_q  <= araw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit: results, latency, hold, back-to-back, reset.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] hi, lo;
  logic        dbz;

  int checks = 0;
  int passed = 0;

  logic [15:0] last_hi, last_lo;
  logic        last_dbz;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .dbz   (dbz)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
  endtask

  // Waits (bounded) for done after an issue; inject >= 0 pulses a DIVU start in that RUN cycle.
  task automatic wait_done(input string nm, input logic [15:0] ehi, input logic [15:0] elo,
                           input logic edbz, input int inject);
    int   edges    = 0;
    int   busy_cnt = 0;
    logic got      = 1'b0;
    logic hold_ok  = 1'b1;
    logic first_busy = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      edges++;
      if (i == inject) begin
        op = 2'b10; a = 16'd100; b = 16'd7; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (i == 0) first_busy = busy;
      if (busy) busy_cnt++;
      if (done) got = 1'b1;
      else if (hi !== last_hi || lo !== last_lo || dbz !== last_dbz) hold_ok = 1'b0;
    end
    check({nm, " done_seen"}, 32'(got), 32'd1);
    check({nm, " latency"}, 32'(edges), 32'd17);
    check({nm, " busy_cycles"}, 32'(busy_cnt), 32'd16);
    check({nm, " busy_first"}, 32'(first_busy), 32'd1);
    check({nm, " busy_in_done"}, 32'(busy), 32'd0);
    check({nm, " hold_during_run"}, 32'(hold_ok), 32'd1);
    check({nm, " hi"}, 32'(hi), 32'(ehi));
    check({nm, " lo"}, 32'(lo), 32'(elo));
    check({nm, " dbz"}, 32'(dbz), 32'(edbz));
    last_hi  = ehi;
    last_lo  = elo;
    last_dbz = edbz;
  endtask

  initial begin
    vecs[0]  = '{"mulu_ffff_ffff", 2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0};
    vecs[1]  = '{"muls_m3_5",      2'b01, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0};
    vecs[2]  = '{"divu_100_7",     2'b10, 16'd100,  16'd7,    16'd2,    16'd14,   1'b0};
    vecs[3]  = '{"divs_m7_2",      2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0};
    vecs[4]  = '{"divs_min_m1",    2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0};
    vecs[5]  = '{"divu_by_zero",   2'b10, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1};
    vecs[6]  = '{"divu_9_3",       2'b10, 16'd9,    16'd3,    16'd0,    16'd3,    1'b0};
    vecs[7]  = '{"muls_min_min",   2'b01, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0};
    vecs[8]  = '{"divs_7_m2",      2'b11, 16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0};
    vecs[9]  = '{"divs_m7_zero",   2'b11, 16'hFFF9, 16'h0000, 16'hFFF9, 16'hFFFF, 1'b1};
    vecs[10] = '{"mulu_0_1234",    2'b00, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0};
    vecs[11] = '{"muls_7_m1",      2'b01, 16'h0007, 16'hFFFF, 16'hFFFF, 16'hFFF9, 1'b0};
    vecs[12] = '{"divu_ffff_1",    2'b10, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0};

    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    last_hi = '0; last_lo = '0; last_dbz = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hi", 32'(hi), 32'd0);
    check("reset lo", 32'(lo), 32'd0);
    check("reset dbz", 32'(dbz), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 13; v++) begin
      issue(vecs[v].op, vecs[v].a, vecs[v].b);
      wait_done(vecs[v].name, vecs[v].hi, vecs[v].lo, vecs[v].dbz, -1);
      @(negedge clk);
      check({vecs[v].name, " done_one_cycle"}, 32'(done), 32'd0);
      repeat (2) @(negedge clk);
    end

    // A start pulse during RUN must be ignored entirely.
    issue(2'b00, 16'd3, 16'd4);
    wait_done("ignore_start", 16'd0, 16'd12, 1'b0, 4);
    @(negedge clk);
    check("ignore_start no_second_op", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // Back-to-back: new request accepted on the edge ending the done cycle.
    issue(2'b10, 16'd9, 16'd3);
    wait_done("b2b_first", 16'd0, 16'd3, 1'b0, -1);
    issue(2'b00, 16'hFFFF, 16'hFFFF);
    wait_done("b2b_second", 16'hFFFE, 16'h0001, 1'b0, -1);
    repeat (2) @(negedge clk);

    // Reset mid-operation abandons it and clears outputs.
    issue(2'b00, 16'd3, 16'd4);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst hi", 32'(hi), 32'd0);
    check("midrst lo", 32'(lo), 32'd0);
    check("midrst dbz", 32'(dbz), 32'd0);
    rst = 1'b0;
    begin
      int done_seen = 0;
      int busy_seen = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (done) done_seen++;
        if (busy) busy_seen++;
      end
      check("midrst no_done_after", 32'(done_seen), 32'd0);
      check("midrst no_busy_after", 32'(busy_seen), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
